mem_region_unit: RTL and testbench

Parametrised, registered successor to the fixed-map memory controller.
- Holds a runtime-programmable table of NUM_REGIONS address windows, each with base, mask, device id and R/W/X permissions.
- Decodes one data access and one instruction fetch per cycle into device id and local address, with one cycle of latency.
- Latches the first access fault with its address and cause, and counts faults.
- Sits between the CPU core and the device mux (ROM, hex display, UART buffer, VGA memory, stack).

---
 rtl/mem_region_unit.sv | 171 +++++++++++++++++
 tb/tb_mem_region_unit.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_region_unit.sv
// Programmable region table that decodes one data access and one fetch per cycle to device id and local address.
// Latency: 1 cycle, registered. No backpressure; the optional MEM_REGION_LOCK_EN build adds a write lock.
module mem_region_unit #(
  parameter int NUM_REGIONS = 8,
  parameter int ADDR_W      = 32,
  parameter int DEV_W       = 3,
  parameter int CNT_W       = 8
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           cfg_we,
  input  logic [$clog2(NUM_REGIONS)-1:0] cfg_idx,
  input  logic                           cfg_en,
  input  logic [ADDR_W-1:0]              cfg_base,
  input  logic [ADDR_W-1:0]              cfg_mask,
  input  logic [2:0]                     cfg_perm,
  input  logic [DEV_W-1:0]               cfg_dev,
`ifdef MEM_REGION_LOCK_EN
  input  logic                           cfg_lock,
  output logic                           cfg_locked,
`endif
  input  logic                           d_req,
  input  logic [ADDR_W-1:0]              d_addr,
  input  logic                           d_we,
  input  logic [1:0]                     d_size,
  input  logic                           i_req,
  input  logic [ADDR_W-1:0]              i_addr,
  input  logic                           fault_clr,
  output logic                           d_valid,
  output logic [DEV_W-1:0]               d_dev,
  output logic [ADDR_W-1:0]              d_addr_local,
  output logic                           i_valid,
  output logic [DEV_W-1:0]               i_dev,
  output logic [ADDR_W-1:0]              i_addr_local,
  output logic [3:0]                     exceptions,
  output logic                           fault_valid,
  output logic                           fault_chan,
  output logic [ADDR_W-1:0]              fault_addr,
  output logic [3:0]                     fault_cause,
  output logic [CNT_W-1:0]               fault_cnt
);

  localparam int IDX_W = $clog2(NUM_REGIONS);

  logic [NUM_REGIONS-1:0] t_en;
  logic [ADDR_W-1:0]      t_base [NUM_REGIONS];
  logic [ADDR_W-1:0]      t_mask [NUM_REGIONS];
  logic [2:0]             t_perm [NUM_REGIONS];
  logic [DEV_W-1:0]       t_dev  [NUM_REGIONS];

  logic wr_en;
  logic lock_fault;

`ifdef MEM_REGION_LOCK_EN
  logic locked_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        locked_q <= 1'b0;
    else if (cfg_lock) locked_q <= 1'b1;
  end
  assign cfg_locked = locked_q;
  assign wr_en      = cfg_we & ~locked_q;
  assign lock_fault = cfg_we & locked_q;
`else
  assign wr_en      = cfg_we;
  assign lock_fault = 1'b0;
`endif

  // Indices outside the table never match k, so such writes fall away.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < NUM_REGIONS; k++) begin
        t_en[k]   <= 1'b0;
        t_base[k] <= '0;
        t_mask[k] <= '0;
        t_perm[k] <= '0;
        t_dev[k]  <= '0;
      end
    end else begin
      for (int k = 0; k < NUM_REGIONS; k++) begin
        if (wr_en && cfg_idx == IDX_W'(k)) begin
          t_en[k]   <= cfg_en;
          t_base[k] <= cfg_base;
          t_mask[k] <= cfg_mask;
          t_perm[k] <= cfg_perm;
          t_dev[k]  <= cfg_dev;
        end
      end
    end
  end

  logic              d_hit, d_r, d_w, i_hit, i_x;
  logic [DEV_W-1:0]  d_dev_c, i_dev_c;
  logic [ADDR_W-1:0] d_loc_c, i_loc_c;

  // Scan from the top so the lowest matching index is the last one written.
  always_comb begin
    d_hit = 1'b0; d_r = 1'b0; d_w = 1'b0; d_dev_c = '0; d_loc_c = '0;
    i_hit = 1'b0; i_x = 1'b0; i_dev_c = '0; i_loc_c = '0;
    for (int k = NUM_REGIONS - 1; k >= 0; k--) begin
      if (t_en[k] && ((d_addr & t_mask[k]) == (t_base[k] & t_mask[k]))) begin
        d_hit   = 1'b1;
        d_r     = t_perm[k][0];
        d_w     = t_perm[k][1];
        d_dev_c = t_dev[k];
        d_loc_c = d_addr & ~t_mask[k];
      end
      if (t_en[k] && ((i_addr & t_mask[k]) == (t_base[k] & t_mask[k]))) begin
        i_hit   = 1'b1;
        i_x     = t_perm[k][2];
        i_dev_c = t_dev[k];
        i_loc_c = i_addr & ~t_mask[k];
      end
    end
  end

  logic [3:0] exc_d;
  logic       probe;
  assign probe    = (d_size == 2'b11);
  assign exc_d[0] = d_req & ~probe & (~d_hit | (d_we ? ~d_w : ~d_r));
  assign exc_d[1] = d_req & (((d_size == 2'b00) & (d_addr[1:0] != 2'b00)) |
                             ((d_size == 2'b01) & d_addr[0]));
  assign exc_d[2] = i_req & (~i_hit | ~i_x);
  assign exc_d[3] = i_req & (i_addr[1:0] != 2'b00);

  logic             any_d, any_i, any_f;
  logic [1:0]       inc;
  logic [CNT_W-1:0] cnt_base, cnt_next;
  logic [CNT_W+1:0] cnt_sum;
  assign any_d    = |exc_d[1:0];
  assign any_i    = |exc_d[3:2];
  assign any_f    = any_d | any_i | lock_fault;
  assign inc      = {1'b0, any_d} + {1'b0, any_i} + {1'b0, lock_fault};
  assign cnt_base = fault_clr ? '0 : fault_cnt;
  assign cnt_sum  = {2'b00, cnt_base} + (CNT_W+2)'(inc);
  assign cnt_next = (cnt_sum[CNT_W+1:CNT_W] != 2'b00) ? '1 : cnt_sum[CNT_W-1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      d_valid      <= 1'b0;
      d_dev        <= '0;
      d_addr_local <= '0;
      i_valid      <= 1'b0;
      i_dev        <= '0;
      i_addr_local <= '0;
      exceptions   <= '0;
      fault_valid  <= 1'b0;
      fault_chan   <= 1'b0;
      fault_addr   <= '0;
      fault_cause  <= '0;
      fault_cnt    <= '0;
    end else begin
      d_valid      <= d_req;
      d_dev        <= d_req ? d_dev_c : '0;
      d_addr_local <= d_req ? d_loc_c : '0;
      i_valid      <= i_req;
      i_dev        <= i_req ? i_dev_c : '0;
      i_addr_local <= i_req ? i_loc_c : '0;
      exceptions   <= exc_d;
      fault_cnt    <= cnt_next;
      if (fault_clr) fault_valid <= 1'b0;
      // A clear in the same cycle frees the record for the new fault.
      if (any_f && (!fault_valid || fault_clr)) begin
        fault_valid <= 1'b1;
        fault_chan  <= ~any_d & any_i;
        fault_addr  <= any_d ? d_addr : (any_i ? i_addr : '0);
        fault_cause <= exc_d;
      end
    end
  end

endmodule

// File: tb/tb_mem_region_unit.sv
// Directed bench for mem_region_unit: a per-cycle reference model plus literal spot checks.
module tb_mem_region_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cfg_we = 1'b0, cfg_en = 1'b0;
  logic [2:0]  cfg_idx = '0, cfg_perm = '0, cfg_dev = '0;
  logic [31:0] cfg_base = '0, cfg_mask = '0;
  logic        d_req = 1'b0, d_we = 1'b0, i_req = 1'b0, fault_clr = 1'b0;
  logic [1:0]  d_size = '0;
  logic [31:0] d_addr = '0, i_addr = '0;
  logic        d_valid, i_valid, fault_valid, fault_chan;
  logic [2:0]  d_dev, i_dev;
  logic [31:0] d_addr_local, i_addr_local, fault_addr;
  logic [3:0]  exceptions, fault_cause;
  logic [7:0]  fault_cnt;

  int checks = 0;
  int errors = 0;
  logic chk_on = 1'b0;

  always #5 clk = ~clk;

  mem_region_unit dut (
    .clk(clk), .rst_n(rst_n),
    .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_en(cfg_en), .cfg_base(cfg_base),
    .cfg_mask(cfg_mask), .cfg_perm(cfg_perm), .cfg_dev(cfg_dev),
    .d_req(d_req), .d_addr(d_addr), .d_we(d_we), .d_size(d_size),
    .i_req(i_req), .i_addr(i_addr), .fault_clr(fault_clr),
    .d_valid(d_valid), .d_dev(d_dev), .d_addr_local(d_addr_local),
    .i_valid(i_valid), .i_dev(i_dev), .i_addr_local(i_addr_local),
    .exceptions(exceptions), .fault_valid(fault_valid), .fault_chan(fault_chan),
    .fault_addr(fault_addr), .fault_cause(fault_cause), .fault_cnt(fault_cnt)
  );

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: the region table as plain arrays, first match wins.
  logic        m_en   [8];
  logic [31:0] m_base [8];
  logic [31:0] m_mask [8];
  logic [2:0]  m_perm [8];
  logic [2:0]  m_dev  [8];

  logic        md_hit, mi_hit;
  logic [2:0]  md_dev, mi_dev, md_perm, mi_perm;
  logic [31:0] md_loc, mi_loc;
  logic [3:0]  m_exc;

  always_comb begin
    md_hit = 1'b0; md_dev = '0; md_perm = '0; md_loc = '0;
    mi_hit = 1'b0; mi_dev = '0; mi_perm = '0; mi_loc = '0;
    for (int k = 0; k < 8; k++) begin
      if (!md_hit && m_en[k] && ((d_addr & m_mask[k]) == (m_base[k] & m_mask[k]))) begin
        md_hit = 1'b1; md_dev = m_dev[k]; md_perm = m_perm[k]; md_loc = d_addr & ~m_mask[k];
      end
      if (!mi_hit && m_en[k] && ((i_addr & m_mask[k]) == (m_base[k] & m_mask[k]))) begin
        mi_hit = 1'b1; mi_dev = m_dev[k]; mi_perm = m_perm[k]; mi_loc = i_addr & ~m_mask[k];
      end
    end
    m_exc = '0;
    if (d_req && d_size != 2'b11) begin
      m_exc[0] = !md_hit || (d_we ? !md_perm[1] : !md_perm[0]);
      m_exc[1] = (d_size == 2'b00 && (d_addr % 4) != 0) || (d_size == 2'b01 && (d_addr % 2) != 0);
    end
    if (i_req) begin
      m_exc[2] = !mi_hit || !mi_perm[2];
      m_exc[3] = (i_addr % 4) != 0;
    end
  end

  function automatic int nfaults(input logic [3:0] e);
    return ((e[1:0] != 0) ? 1 : 0) + ((e[3:2] != 0) ? 1 : 0);
  endfunction

  function automatic logic [7:0] sat_add(input int base, input int n);
    int s;
    s = base + n;
    return (s > 255) ? 8'd255 : 8'(s);
  endfunction

  logic        e_dv, e_iv, mf_valid, mf_chan;
  logic [2:0]  e_ddev, e_idev;
  logic [31:0] e_dloc, e_iloc, mf_addr;
  logic [3:0]  e_exc, mf_cause;
  logic [7:0]  mf_cnt;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < 8; k++) begin
        m_en[k] <= 1'b0; m_base[k] <= '0; m_mask[k] <= '0; m_perm[k] <= '0; m_dev[k] <= '0;
      end
      e_dv <= 1'b0; e_iv <= 1'b0; e_ddev <= '0; e_idev <= '0; e_dloc <= '0; e_iloc <= '0;
      e_exc <= '0; mf_valid <= 1'b0; mf_chan <= 1'b0; mf_addr <= '0; mf_cause <= '0; mf_cnt <= '0;
    end else begin
      e_dv   <= d_req;
      e_ddev <= d_req ? md_dev : 3'd0;
      e_dloc <= d_req ? md_loc : 32'd0;
      e_iv   <= i_req;
      e_idev <= i_req ? mi_dev : 3'd0;
      e_iloc <= i_req ? mi_loc : 32'd0;
      e_exc  <= m_exc;
      mf_cnt <= sat_add(fault_clr ? 0 : int'(mf_cnt), nfaults(m_exc));
      if (nfaults(m_exc) > 0 && (!mf_valid || fault_clr)) begin
        mf_valid <= 1'b1;
        mf_chan  <= (m_exc[1:0] == 2'b00);
        mf_addr  <= (m_exc[1:0] != 2'b00) ? d_addr : i_addr;
        mf_cause <= m_exc;
      end else if (fault_clr) begin
        mf_valid <= 1'b0;
      end
      if (cfg_we) begin
        m_en[cfg_idx] <= cfg_en; m_base[cfg_idx] <= cfg_base; m_mask[cfg_idx] <= cfg_mask;
        m_perm[cfg_idx] <= cfg_perm; m_dev[cfg_idx] <= cfg_dev;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_on) begin
      cmp("m_d_valid", d_valid, e_dv);
      cmp("m_d_dev", d_dev, e_ddev);
      cmp("m_d_local", d_addr_local, e_dloc);
      cmp("m_i_valid", i_valid, e_iv);
      cmp("m_i_dev", i_dev, e_idev);
      cmp("m_i_local", i_addr_local, e_iloc);
      cmp("m_exc", exceptions, e_exc);
      cmp("m_fault_valid", fault_valid, mf_valid);
      if (mf_valid) begin
        cmp("m_fault_chan", fault_chan, mf_chan);
        cmp("m_fault_addr", fault_addr, mf_addr);
        cmp("m_fault_cause", fault_cause, mf_cause);
      end
      cmp("m_fault_cnt", fault_cnt, mf_cnt);
    end
  end

  // Stage a table write; it is committed by the next go().
  task automatic cfg(input int idx, input logic en, input logic [31:0] base, input logic [31:0] mask,
                     input logic [2:0] perm, input logic [2:0] dev);
    cfg_we = 1'b1; cfg_idx = 3'(idx); cfg_en = en; cfg_base = base; cfg_mask = mask;
    cfg_perm = perm; cfg_dev = dev;
  endtask

  task automatic go(input logic dr, input logic [31:0] da, input logic dwe, input logic [1:0] dsz,
                    input logic ir, input logic [31:0] ia, input logic clr);
    d_req = dr; d_addr = da; d_we = dwe; d_size = dsz; i_req = ir; i_addr = ia; fault_clr = clr;
    @(negedge clk);
    d_req = 1'b0; i_req = 1'b0; fault_clr = 1'b0; cfg_we = 1'b0;
  endtask

  initial begin
    repeat (2) @(negedge clk);
    cmp("rst_d_valid", d_valid, 0);
    cmp("rst_exc", exceptions, 0);
    cmp("rst_fault_valid", fault_valid, 0);
    cmp("rst_fault_cnt", fault_cnt, 0);
    chk_on = 1'b1;
    rst_n = 1'b1;
    @(negedge clk);

    // Unmapped read after reset.
    go(1, 32'h2000, 0, 2'b00, 0, 0, 0);
    cmp("unmap_valid", d_valid, 1);
    cmp("unmap_dev", d_dev, 0);
    cmp("unmap_exc", exceptions, 4'b0001);
    cmp("unmap_fv", fault_valid, 1);
    cmp("unmap_faddr", fault_addr, 32'h2000);
    cmp("unmap_cnt", fault_cnt, 1);

    cfg(1, 1, 32'h2000, 32'hFFFF_FC00, 3'b101, 3'd1);
    go(0, 0, 0, 2'b00, 0, 0, 0);
    go(1, 32'h2004, 1, 2'b00, 0, 0, 0);
    cmp("wr_ro_dev", d_dev, 1);
    cmp("wr_ro_local", d_addr_local, 32'h4);
    cmp("wr_ro_exc", exceptions, 4'b0001);
    cmp("first_fault_kept", fault_addr, 32'h2000);
    cmp("wr_ro_cnt", fault_cnt, 2);
    go(0, 0, 0, 2'b00, 1, 32'h2008, 0);
    cmp("fetch_dev", i_dev, 1);
    cmp("fetch_local", i_addr_local, 32'h8);
    cmp("fetch_exc", exceptions, 4'b0000);

    // Overlapping windows: index 0 wins.
    cfg(0, 1, 32'hFFFF_F000, 32'hFFFF_F000, 3'b111, 3'd5);
    go(0, 0, 0, 2'b00, 0, 0, 0);
    cfg(3, 1, 32'hFFFF_0000, 32'hFFFF_0000, 3'b111, 3'd2);
    go(0, 0, 0, 2'b00, 0, 0, 0);
    go(1, 32'hFFFF_F010, 0, 2'b00, 0, 0, 0);
    cmp("prio_dev", d_dev, 5);
    cmp("prio_local", d_addr_local, 32'h10);
    go(1, 32'hFFFF_1234, 0, 2'b00, 0, 0, 0);
    cmp("low_prio_dev", d_dev, 2);
    cmp("low_prio_local", d_addr_local, 32'h1234);

    go(0, 0, 0, 2'b00, 0, 0, 1);
    cmp("clr_fv", fault_valid, 0);
    cmp("clr_cnt", fault_cnt, 0);
    cfg(2, 1, 32'h0, 32'hFFFF_F000, 3'b011, 3'd3);
    go(0, 0, 0, 2'b00, 0, 0, 0);
    go(1, 32'h101, 0, 2'b01, 1, 32'h2002, 0);
    cmp("dual_exc", exceptions, 4'b1010);
    cmp("dual_chan", fault_chan, 0);
    cmp("dual_addr", fault_addr, 32'h101);
    cmp("dual_cnt", fault_cnt, 2);
    go(1, 32'h2000, 1, 2'b00, 0, 0, 1);
    cmp("clrnew_cnt", fault_cnt, 1);
    cmp("clrnew_addr", fault_addr, 32'h2000);
    cmp("clrnew_cause", fault_cause, 4'b0001);
    go(0, 0, 0, 2'b00, 0, 0, 1);
    go(0, 0, 0, 2'b00, 1, 32'h3000, 0);
    cmp("fetch_fault_chan", fault_chan, 1);
    cmp("fetch_fault_addr", fault_addr, 32'h3000);
    cmp("fetch_fault_cause", fault_cause, 4'b0100);
    go(1, 32'h5003, 0, 2'b11, 0, 0, 0);
    cmp("probe_valid", d_valid, 1);
    cmp("probe_exc", exceptions, 4'b0000);
    cmp("probe_cnt", fault_cnt, 1);

    for (int n = 0; n < 300; n++) go(1, 32'h9000, 0, 2'b00, 0, 0, 0);
    cmp("sat_cnt", fault_cnt, 255);
    go(1, 32'h9000, 0, 2'b00, 1, 32'h9001, 0);
    cmp("sat_hold", fault_cnt, 255);

    // Same-cycle rewrite decodes against the old entry.
    cfg(2, 1, 32'h0, 32'hFFFF_F000, 3'b011, 3'd4);
    go(1, 32'h10, 0, 2'b00, 0, 0, 0);
    cmp("old_map_dev", d_dev, 3);
    go(1, 32'h10, 0, 2'b00, 0, 0, 0);
    cmp("new_map_dev", d_dev, 4);
    cfg(2, 0, 32'h0, 32'hFFFF_F000, 3'b011, 3'd4);
    go(0, 0, 0, 2'b00, 0, 0, 0);
    go(1, 32'h10, 0, 2'b00, 0, 0, 0);
    cmp("disabled_dev", d_dev, 0);
    cmp("disabled_local", d_addr_local, 0);

    // Asynchronous reset between clock edges.
    #2 rst_n = 1'b0;
    #1;
    cmp("arst_d_valid", d_valid, 0);
    cmp("arst_fv", fault_valid, 0);
    cmp("arst_cnt", fault_cnt, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    go(1, 32'h2004, 0, 2'b00, 0, 0, 0);
    cmp("arst_table_dev", d_dev, 0);
    cmp("arst_table_exc", exceptions, 4'b0001);
    repeat (2) @(negedge clk);

    chk_on = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
